seq_share_ctrl: RTL
===================

# seq_share_ctrl

Round-robin controller that time-shares one external 2-bit serial sequence unit among `N_REQ` requesters. The sequence unit has input `A`, output `Y`, and an active-low reset. Each requester submits a parallel bit pattern and a length. The controller arbitrates, clears the unit, shifts the pattern into it LSB-first, counts the cycles in which the unit reports its terminal state, and returns that count with a done pulse. It sits between the requester blocks and the single shared sequence unit.

## Interface
- `N_REQ`, default 4: number of requesters (≥2).
- `DATA_W`, default 8: pattern width per requester.
- `LEN_W`, default 4: length and hit-count width; must satisfy 2^LEN_W > DATA_W.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N_REQ: per-requester job request, level.
- `data` in N_REQ*DATA_W: flattened patterns; requester i uses bits [i*DATA_W +: DATA_W].
- `len` in N_REQ*LEN_W: flattened bit counts; requester i uses bits [i*LEN_W +: LEN_W].
- `gnt` out N_REQ: one-hot grant, held for the whole job.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `done_id` out clog2(N_REQ): index of the completed requester, valid with `done`.
- `hit_cnt` out LEN_W: terminal-state count, valid with `done`.
- `unit_a` out 1: serial bit to the shared unit.
- `unit_rst_n` out 1: active-low reset to the shared unit.
- `unit_y` in 1: registered terminal flag from the shared unit.

## Operation
- **Shared unit contract.** State (q1,q0) advances each clock: q0' = ~q0, q1' = A^q1^q0. `unit_y` is registered as q0&q1. All three bits are 0 while `unit_rst_n`=0.
- **FSM states:** IDLE, CLEAR, RUN, DRAIN, DONE.
- **IDLE.** If `req` is nonzero, pick a winner by round-robin and go to CLEAR.
  - Round-robin search starts at the index after the last granted requester. After reset the search starts at index 0.
  - At the transition, latch the winner's data and len, and assert its `gnt`.
- **CLEAR** (1 cycle). `unit_rst_n`=0. Go to RUN, or to DRAIN if the latched len is 0.
- **RUN** (len cycles). At relative cycle t = 0..len-1, `unit_a` = latched data bit t.
- **DRAIN** (2 cycles). `unit_a`=0.
- **Hit counting.** Relative cycle t counts from the first RUN cycle and continues through DRAIN. In cycles where 2 ≤ t ≤ len+1, add 1 to the hit accumulator when `unit_y`=1. The result is the number of bits i in 1..len after which the unit state is 11.
- **DONE** (1 cycle). `done`=1, `done_id` = winner index, `hit_cnt` = accumulator. `gnt` drops at the end of DONE. Return to IDLE.
- **Length clamping.** A len greater than DATA_W is treated as DATA_W.
- **Requester obligations and ignored inputs.**
  - A requester must drop `req` in the cycle after its `done`. A held `req` is re-arbitrated fairly in round-robin order.
  - Changes to `req`, `data` or `len` of the granted requester after the grant are ignored.
- **Idle output values.** Outside CLEAR: `unit_rst_n`=1. Outside RUN: `unit_a`=0.
- **Reset.** Reset mid-job aborts the job: back to IDLE, no `done` pulse, accumulator cleared, RR pointer reset.

## Timing
- **Reset values:** `gnt`=0, `busy`=0, `done`=0, `done_id`=0, `hit_cnt`=0, `unit_a`=0, `unit_rst_n`=0 during reset and 1 afterwards.
- **Job sequence.** With `req` first sampled high in IDLE at cycle 0:
  - Cycle 1: `gnt` and `busy` high; CLEAR.
  - Cycles 2..len+1: RUN.
  - Cycles len+2..len+3: DRAIN.
  - Cycle len+4: `done`.
- **Job latency** is len+4 cycles. The next arbitration happens in the IDLE cycle after DONE, so back-to-back jobs are spaced len+5 cycles apart.
- **Stable outputs.** `hit_cnt` and `done_id` keep their values until the next DONE.
- **Registered outputs.** All outputs are registered and glitch-free. `unit_y` is sampled only on the rising edge.
- **Reset while `req` is high.** Reset asserted in the same cycle as a `req` edge wins: no grant is issued.

## Test plan
- **Single all-zero job.** After reset, req=0001, data0=0x00, len0=4 → `gnt`=0001 from cycle 1; unit_a=0,0,0,0; `done` at cycle 8 with done_id=0 and hit_cnt=1 (states 01,10,11,00).
- **All-one job, then length 8.**
  - data=0x0F, len=4 → RUN bits 1,1,1,1; states 11,10,01,00; hit_cnt=1.
  - data=0x00, len=8 → hit_cnt=2, `done` 12 cycles after the request.
- **Round-robin fairness.** req=1111 held, every len=1.
  - Grants are in order 0,1,2,3,0, with done_id matching.
  - No grant is issued before the previous DONE.
- **Zero length.** len=0 → CLEAR, DRAIN, DRAIN, DONE with hit_cnt=0 and unit_a=0 throughout.
- **Length clamping.** len=15 with DATA_W=8 → exactly 8 RUN cycles.
- **Mid-job reset.** `rst` asserted at the 3rd RUN cycle.
  - Next cycle: gnt=0, busy=0, unit_rst_n=0, and no `done`.
  - After release, req=0010 is granted first (pointer reset to index 0; requester 0 idle).

Source files
------------

// File: rtl/seq_share_ctrl.sv
// seq_share_ctrl: round-robin time-sharing of one serial 2-bit sequence unit among N_REQ requesters
module seq_share_ctrl #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data,
    input  logic [N_REQ*LEN_W-1:0]    len,
    output logic [N_REQ-1:0]          gnt,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(N_REQ)-1:0]  done_id,
    output logic [LEN_W-1:0]          hit_cnt,
    output logic                      unit_a,
    output logic                      unit_rst_n,
    input  logic                      unit_y
);
    localparam int IW = $clog2(N_REQ);
    localparam int TW = LEN_W + 1;
    localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, RUN = 3'd2, DRAIN = 3'd3, DONE = 3'd4;
    logic [2:0]        state;
    logic [IW-1:0]     ptr, win, pick;
    logic [DATA_W-1:0] sh;
    logic [LEN_W-1:0]  len_q, len_raw, len_c, acc, acc_nxt;
    logic [TW-1:0]     t;
    logic              hit;
    always_comb begin
        pick = ptr;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % N_REQ]) pick = IW'((int'(ptr) + i) % N_REQ);
    end
    assign len_raw = len[pick*LEN_W +: LEN_W];
    assign len_c   = (len_raw > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : len_raw;
    // unit_y lags the unit state by one cycle, so t=2..len+1 sees the states after bits 1..len
    assign hit     = unit_y && (t >= TW'(2));
    assign acc_nxt = acc + LEN_W'(hit);
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            win        <= '0;
            sh         <= '0;
            len_q      <= '0;
            acc        <= '0;
            t          <= '0;
            gnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_id    <= '0;
            hit_cnt    <= '0;
            unit_a     <= 1'b0;
            unit_rst_n <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    unit_rst_n <= ~|req;
                    if (|req) begin
                        state <= CLEAR;
                        win   <= pick;
                        gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                        busy  <= 1'b1;
                        sh    <= data[pick*DATA_W +: DATA_W];
                        len_q <= len_c;
                        acc   <= '0;
                    end
                end
                CLEAR: begin
                    unit_rst_n <= 1'b1;
                    t          <= '0;
                    state      <= (len_q == '0) ? DRAIN : RUN;
                    unit_a     <= (len_q != '0) && sh[0];
                    sh         <= sh >> 1;
                end
                RUN: begin
                    t      <= t + TW'(1);
                    acc    <= acc_nxt;
                    state  <= (t + TW'(1) == TW'(len_q)) ? DRAIN : RUN;
                    unit_a <= (t + TW'(1) != TW'(len_q)) && sh[0];
                    sh     <= sh >> 1;
                end
                DRAIN: begin
                    t   <= t + TW'(1);
                    acc <= acc_nxt;
                    if (t == TW'(len_q) + TW'(1)) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        done_id <= win;
                        hit_cnt <= acc_nxt;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    ptr   <= (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
